// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
// The optional source-ID header is enabled with the UART_ARB_HDR_EN macro.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'h80;

    // Index width for a requester count; never below one bit.
    function automatic int clog2_ports(input int ports);
        int w;
        w = 0;
        while ((1 << w) < ports) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after i_last_idx, wrapping, wins.
// Reusable by any packet-granular shared-resource arbiter.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IW    = clog2_ports(PORTS)
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [IW-1:0]    i_last_idx,
    output logic [PORTS-1:0] o_gnt,
    output logic [IW-1:0]    o_gnt_idx,
    output logic             o_any
);

    // One extra bit so last_idx + offset never overflows before the wrap compare.
    localparam int CW = IW + 1;

    logic [CW-1:0]    w_cand;
    logic [PORTS-1:0] w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_any;

    // Walk the candidates in priority order and keep the first active request.
    always_comb begin
        w_cand = '0;
        w_gnt  = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        for (int off = 1; off <= PORTS; off++) begin
            w_cand = {1'b0, i_last_idx} + CW'(off);
            if (w_cand > CW'(PORTS - 1)) begin
                w_cand = w_cand - CW'(PORTS);
            end else begin
                w_cand = w_cand;
            end
            if (!w_any && i_req[w_cand[IW-1:0]]) begin
                w_any                = 1'b1;
                w_gnt[w_cand[IW-1:0]] = 1'b1;
                w_idx                = w_cand[IW-1:0];
            end else begin
                w_any = w_any;
            end
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;
    assign o_any     = w_any;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmitter through a registered stage.
// Define UART_ARB_HDR_EN to prefix each packet with a source-ID byte HDR_BASE + port index.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PORTS      = 4
`ifdef UART_ARB_HDR_EN
    ,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [PORTS-1:0]            grant,
    output logic                        busy
);

    localparam int IW = clog2_ports(PORTS);

    state_t                r_state;
    logic [PORTS-1:0]      r_grant;
    logic [IW-1:0]         r_gnt_idx;
    logic [IW-1:0]         r_last_idx;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;

    logic [PORTS-1:0]      w_pick_gnt;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_pick_any;
    logic                  w_free;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [PORTS-1:0]      w_sready;

    rr_pick #(.PORTS(PORTS)) u_pick (
        .i_req      (s_axis_tvalid),
        .i_last_idx (r_last_idx),
        .o_gnt      (w_pick_gnt),
        .o_gnt_idx  (w_pick_idx),
        .o_any      (w_pick_any)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign w_free = !r_tvalid || m_axis_tready;

    // One-hot grant steers the granted lane; other lanes are never sampled.
    always_comb begin
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (r_grant[i]) begin
                w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last  = s_axis_tlast[i];
                w_sel_valid = s_axis_tvalid[i];
            end else begin
                w_sel_data = w_sel_data;
            end
        end
    end

    assign w_sready = ((r_state == ST_DATA) && w_free) ? r_grant : '0;
    assign w_accept = (r_state == ST_DATA) && w_free && w_sel_valid;

`ifdef UART_ARB_HDR_EN
    logic                  w_hdr_load;
    logic [DATA_WIDTH-1:0] w_hdr_byte;

    assign w_hdr_load  = (r_state == ST_HDR) && w_free;
    assign w_hdr_byte  = DATA_WIDTH'(HDR_BASE) + DATA_WIDTH'(r_gnt_idx);
    assign w_load      = w_accept || w_hdr_load;
    assign w_load_data = w_hdr_load ? w_hdr_byte : w_sel_data;
`else
    assign w_load      = w_accept;
    assign w_load_data = w_sel_data;
`endif

    // Arbitration FSM plus the single output pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gnt_idx  <= '0;
            r_last_idx <= IW'(PORTS - 1);
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
        end else begin
            if (w_load) begin
                r_tdata  <= w_load_data;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end else begin
                r_tvalid <= r_tvalid;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant   <= w_pick_gnt;
                        r_gnt_idx <= w_pick_idx;
`ifdef UART_ARB_HDR_EN
                        r_state   <= ST_HDR;
`else
                        r_state   <= ST_DATA;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef UART_ARB_HDR_EN
                ST_HDR: begin
                    if (w_hdr_load) begin
                        r_state <= ST_DATA;
                    end else begin
                        r_state <= ST_HDR;
                    end
                end
`endif
                ST_DATA: begin
                    if (w_accept && w_sel_last) begin
                        r_last_idx <= r_gnt_idx;
                        r_grant    <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_sready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign grant         = r_grant;
    assign busy          = (r_state != ST_IDLE) || r_tvalid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases and
// randomized packet traffic against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tready;
    logic [PORTS-1:0]      s_tlast;
    logic [DW-1:0]         m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [PORTS-1:0]      grant;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .PORTS(PORTS)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .grant         (grant),
        .busy          (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        mready;
        logic [3:0]  e_grant;
        logic [3:0]  e_sready;
        logic        e_mvalid;
        logic [7:0]  e_mdata;
        logic        e_busy;
    } vec_t;

    beat_t      port_q[PORTS][$];
    logic [7:0] exp_q[$];
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        port_q[p].push_back(b);
    endtask

    // Packet-level model: whole packets go out in round-robin order over ports with work left.
    task automatic model_expect();
        beat_t mq[PORTS][$];
        beat_t b;
        int    last_p;
        int    p;
        bit    found;
        for (int i = 0; i < PORTS; i++) mq[i] = port_q[i];
        last_p = PORTS - 1;
        do begin
            found = 1'b0;
            for (int off = 1; off <= PORTS; off++) begin
                p = (last_p + off) % PORTS;
                if (!found && mq[p].size() > 0) begin
                    found  = 1'b1;
                    last_p = p;
`ifdef UART_ARB_HDR_EN
                    exp_q.push_back(8'h80 + 8'(p));
`endif
                    do begin
                        b = mq[p].pop_front();
                        exp_q.push_back(b.data);
                    end while (!b.last);
                end
            end
        end while (found);
    endtask

    // Drives every queued packet, randomizes sink stalls and mid-packet valid gaps.
    task automatic run_stream(input int ready_pct, input int gap_pct, input int budget);
        bit first[PORTS];
        int cyc;
        for (int i = 0; i < PORTS; i++) first[i] = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            for (int p = 0; p < PORTS; p++) begin
                if (port_q[p].size() > 0) begin
                    s_tvalid[p]         = first[p] ? 1'b1 : ($urandom_range(99) >= gap_pct);
                    s_tdata[p*DW +: DW] = port_q[p][0].data;
                    s_tlast[p]          = port_q[p][0].last;
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tlast[p]  = 1'b0;
                end
            end
            m_tready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            check("ready_outside_grant", 32'(s_tready & ~grant), 32'd0);
            for (int p = 0; p < PORTS; p++) begin
                if (s_tvalid[p] && s_tready[p]) begin
                    first[p] = port_q[p][0].last;
                    void'(port_q[p].pop_front());
                end
            end
            if (m_tvalid && m_tready && exp_q.size() > 0) begin
                check("stream_byte", 32'(m_tdata), 32'(exp_q.pop_front()));
            end
            tick();
            cyc++;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        idle_inputs();
        for (int p = 0; p < PORTS; p++) port_q[p].delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npk;
        int len;

        // Port 2 alone sends 0x41, 0x42(tlast) with an always-ready sink.
        vecs[0] = '{valid:4'b0100, last:4'b0000, data:32'h0041_0000, mready:1'b1,
                    e_grant:4'b0000, e_sready:4'b0000, e_mvalid:1'b0, e_mdata:8'h00, e_busy:1'b0};
        vecs[1] = '{valid:4'b0100, last:4'b0000, data:32'h0041_0000, mready:1'b1,
                    e_grant:4'b0100, e_sready:4'b0100, e_mvalid:1'b0, e_mdata:8'h00, e_busy:1'b1};
        vecs[2] = '{valid:4'b0100, last:4'b0100, data:32'h0042_0000, mready:1'b1,
                    e_grant:4'b0100, e_sready:4'b0100, e_mvalid:1'b1, e_mdata:8'h41, e_busy:1'b1};
        vecs[3] = '{valid:4'b0000, last:4'b0000, data:32'h0000_0000, mready:1'b1,
                    e_grant:4'b0000, e_sready:4'b0000, e_mvalid:1'b1, e_mdata:8'h42, e_busy:1'b1};
        vecs[4] = '{valid:4'b0000, last:4'b0000, data:32'h0000_0000, mready:1'b1,
                    e_grant:4'b0000, e_sready:4'b0000, e_mvalid:1'b0, e_mdata:8'h42, e_busy:1'b0};

        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        check("rst_sready", 32'(s_tready), 32'd0);
        check("rst_mvalid", 32'(m_tvalid), 32'd0);
        check("rst_mdata",  32'(m_tdata),  32'd0);
        check("rst_grant",  32'(grant),    32'd0);
        check("rst_busy",   32'(busy),     32'd0);
        tick();
        rst = 1'b0;

`ifndef UART_ARB_HDR_EN
        for (int k = 0; k < 5; k++) begin
            s_tvalid = vecs[k].valid;
            s_tlast  = vecs[k].last;
            s_tdata  = vecs[k].data;
            m_tready = vecs[k].mready;
            @(negedge clk);
            check($sformatf("vec%0d_grant", k),  32'(grant),    32'(vecs[k].e_grant));
            check($sformatf("vec%0d_sready", k), 32'(s_tready), 32'(vecs[k].e_sready));
            check($sformatf("vec%0d_mvalid", k), 32'(m_tvalid), 32'(vecs[k].e_mvalid));
            check($sformatf("vec%0d_mdata", k),  32'(m_tdata),  32'(vecs[k].e_mdata));
            check($sformatf("vec%0d_busy", k),   32'(busy),     32'(vecs[k].e_busy));
            tick();
        end
`endif

        // All ports busy with two-beat packets: grant order 0,1,2,3 with no interleave.
        do_reset();
        for (int i = 0; i < PORTS; i++) begin
            push_beat(i, 8'h10 + 8'(i), 1'b0);
            push_beat(i, 8'h20 + 8'(i), 1'b1);
`ifdef UART_ARB_HDR_EN
            exp_q.push_back(8'h80 + 8'(i));
`endif
            exp_q.push_back(8'h10 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        run_stream(100, 0, 200);

`ifdef UART_ARB_HDR_EN
        do_reset();
        push_beat(3, 8'h55, 1'b1);
        exp_q.push_back(8'h83);
        exp_q.push_back(8'h55);
        run_stream(100, 0, 50);
`else
        // Sink stall mid-packet on port 1 while port 3 waits.
        do_reset();
        s_tvalid = 4'b1010; s_tdata = 32'hB000_A000; s_tlast = 4'b1000; m_tready = 1'b1;
        @(negedge clk); check("st_idle_grant", 32'(grant), 32'd0); tick();
        @(negedge clk); check("st_grant", 32'(grant), 32'h2); check("st_sready", 32'(s_tready), 32'h2); tick();
        s_tdata = 32'hB000_A100; m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("st_hold_sready", 32'(s_tready), 32'd0);
            check("st_hold_mvalid", 32'(m_tvalid), 32'd1);
            check("st_hold_mdata",  32'(m_tdata),  32'hA0);
            check("st_hold_grant",  32'(grant),    32'h2);
            tick();
        end
        m_tready = 1'b1;
        @(negedge clk); check("st_resume_sready", 32'(s_tready), 32'h2); tick();
        s_tdata = 32'hB000_A200; s_tlast = 4'b1010;
        @(negedge clk); check("st_a1", 32'(m_tdata), 32'hA1); check("st_a1_grant", 32'(grant), 32'h2); tick();
        s_tvalid = 4'b1000; s_tlast = 4'b1000;
        @(negedge clk); check("st_a2", 32'(m_tdata), 32'hA2); check("st_rel_grant", 32'(grant), 32'd0); tick();
        @(negedge clk); check("st_port3_grant", 32'(grant), 32'h8); tick();

        // Port 0 drops valid between beats; port 1 must keep waiting.
        do_reset();
        s_tvalid = 4'b0011; s_tdata = 32'h0000_D0C0; s_tlast = 4'b0010; m_tready = 1'b1;
        @(negedge clk); check("gap_idle_grant", 32'(grant), 32'd0); tick();
        @(negedge clk); check("gap_grant", 32'(grant), 32'h1); check("gap_sready", 32'(s_tready), 32'h1); tick();
        s_tvalid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_hold_grant",  32'(grant),    32'h1);
            check("gap_hold_sready", 32'(s_tready), 32'h1);
            check("gap_hold_mdata",  32'(m_tdata),  32'hC0);
            tick();
        end
        s_tvalid = 4'b0011; s_tdata = 32'h0000_D0C1; s_tlast = 4'b0011;
        @(negedge clk); check("gap_last_sready", 32'(s_tready), 32'h1); tick();
        s_tvalid = 4'b0010; s_tlast = 4'b0010;
        @(negedge clk);
        check("gap_c1", 32'(m_tdata), 32'hC1);
        check("gap_c1_valid", 32'(m_tvalid), 32'd1);
        check("gap_rel_grant", 32'(grant), 32'd0);
        tick();
        @(negedge clk); check("gap_port1_grant", 32'(grant), 32'h2); tick();

        // Reset during beat 2 of a 4-beat packet.
        do_reset();
        s_tvalid = 4'b0001; s_tdata = 32'h0000_00E0; s_tlast = 4'b0000; m_tready = 1'b1;
        tick();
        @(negedge clk); check("mr_grant", 32'(grant), 32'h1); tick();
        s_tdata = 32'h0000_00E1;
        @(negedge clk); check("mr_e0", 32'(m_tdata), 32'hE0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mr_mvalid", 32'(m_tvalid), 32'd0);
        check("mr_grant0", 32'(grant),    32'd0);
        check("mr_sready", 32'(s_tready), 32'd0);
        check("mr_busy",   32'(busy),     32'd0);
        tick();
        rst = 1'b0; s_tvalid = 4'b0011; s_tdata = 32'h0000_F0E0;
        @(negedge clk); check("mr_idle_grant", 32'(grant), 32'd0); tick();
        @(negedge clk); check("mr_port0_prio", 32'(grant), 32'h1); tick();
        idle_inputs();
`endif

        // Randomized packets with stalls and valid gaps against the packet model.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int p = 0; p < PORTS; p++) begin
                npk = $urandom_range(3, 0);
                for (int k = 0; k < npk; k++) begin
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) begin
                        push_beat(p, 8'($urandom_range(255)), (b == len - 1));
                    end
                end
            end
            model_expect();
            run_stream(r == 0 ? 70 : 40, r == 0 ? 30 : 50, 3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit AXI-Stream input among N requesters; the output feeds the UART transmitter's s_axis_* port.
- Arbitration is round-robin at packet granularity. A grant is held from the first beat of a packet until the beat carrying tlast is accepted, so bytes from different sources never interleave on the serial line.
- The output is registered: one pipeline stage, full AXI-Stream backpressure.

Parameters:
- DATA_WIDTH, 8, byte width. Must match the UART transmitter.
- PORTS, 4, number of requesters, 2..16.
- HDR_BASE, 8'h80, base value of the source-ID header byte. Used only when UART_ARB_HDR_EN is defined.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- s_axis_tdata  input  PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  input  PORTS  per-requester valid
- s_axis_tready  output  PORTS  per-requester ready
- s_axis_tlast  input  PORTS  per-requester end of packet
- m_axis_tdata  output  DATA_WIDTH  to the UART transmitter
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  from the UART transmitter
- grant  output  PORTS  one-hot current grant; zero when idle
- busy  output  1  high while in any state other than IDLE, or while m_axis_tvalid is high

Behaviour:
- Reset values:
  - outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, grant=0, busy=0
  - internal: state=IDLE, last_idx=PORTS-1, so port 0 has highest priority after reset.
- FSM states: IDLE, HDR (present only with UART_ARB_HDR_EN), DATA. Encodings live in the package.
- IDLE:
  - When any s_axis_tvalid is high, select the first valid index searching last_idx+1, last_idx+2, ..., wrapping modulo PORTS.
  - Register grant (one-hot) and gnt_idx; next state is DATA, or HDR with the macro.
  - Arbitration costs exactly one cycle; s_axis_tready stays 0 in IDLE.
- DATA:
  - s_axis_tready[i] = grant[i] && (!m_axis_tvalid || m_axis_tready). All other ready bits are 0 (combinational from registers and m_axis_tready).
  - On accept (valid && ready of the granted port): load the output register with the port's tdata; m_axis_tvalid=1 on the next cycle.
  - If the accepted beat has tlast=1: last_idx<=gnt_idx, grant<=0, state<=IDLE.
- Output register:
  - Cleared (m_axis_tvalid<=0) when m_axis_tready && m_axis_tvalid with no new load in the same cycle.
  - Load and drain in the same cycle gives back-to-back throughput of 1 beat/cycle.
- The granted requester may drop tvalid between beats. The grant is held indefinitely; the block has no timeout.
- A single-beat packet (tlast on the first beat) is legal; grant is released after that one beat.
- Non-granted requesters asserting valid are ignored until the next IDLE arbitration. Their data is never sampled.
- Fairness:
  - After port k finishes, port k has lowest priority.
  - With all ports continuously valid, the grant order is 0,1,...,PORTS-1,0,...
- Packet gap: 1 idle input cycle between packets (the IDLE arbitration cycle). The output register may still be draining during that cycle.
- IDLE can re-enter arbitration while m_axis_tvalid=1 (last beat not yet taken).
- Reset mid-packet:
  - Returns to the reset values above.
  - A partially sent packet is abandoned and the output beat is dropped.
  - The requester must restart its packet.
- Width rule: gnt_idx and last_idx are $clog2(PORTS) bits; the wrap uses an explicit compare against PORTS-1, not natural overflow.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - After arbitration, state HDR inserts one header byte HDR_BASE+gnt_idx, sum truncated to DATA_WIDTH, into the output register. The byte is loaded when the register is free.
  - HDR then goes to DATA. s_axis_tready stays 0 during HDR.
  - Each packet costs one extra output byte and at least one extra cycle.
- Undefined: HDR state and HDR_BASE logic are absent; IDLE goes directly to DATA.

Decomposition:
- Package uart_arb_pkg:
  - state localparams (IDLE, HDR, DATA)
  - index-width function clog2_ports
  - default HDR_BASE constant
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req[PORTS], last_idx. Outputs: one-hot gnt, gnt_idx, any.
  - Reusable by other shared-resource arbiters in the SoC.

Test Plan:
- Reset then port 2 only, packet 0x41,0x42(tlast), m_axis_tready=1 -> grant=0b0100 one cycle after valid; m_axis emits 0x41,0x42 on consecutive cycles; grant returns to 0.
- Ports 0..3 all valid with 2-beat packets {0x10+i,0x20+i(tlast)} -> output 0x10,0x20,0x11,0x21,0x12,0x22,0x13,0x23; no interleaving.
- Port 1 mid-packet with port 3 valid; m_axis_tready held 0 for 5 cycles -> s_axis_tready[1]=0 while m_axis_tvalid=1; data stable; port 3 not granted until port 1 tlast is accepted.
- Port 0 drops valid for 3 cycles between beats -> grant stays 0b0001; port 1 valid meanwhile is not served; packet completes intact.
- Assert rst during beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, grant=0, s_axis_tready=0; after release, port 0 has priority.
- With UART_ARB_HDR_EN, HDR_BASE=0x80, port 3 sends 0x55(tlast) -> output 0x83,0x55.
